// File: rtl/rv_alu_pipe.sv
// Three-stage RV32I/RV64I OP/OP-IMM execute pipeline (decode, execute, writeback)
// with an internal register file, full operand forwarding and illegal-instruction flagging.
module rv_alu_pipe #(
  parameter int R1_INIT = 209,
  parameter int R2_INIT = -208,
  parameter int XLEN    = 32,
  parameter int NREGS   = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic            retire_valid,
  input  logic            retire_ready,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            retire_illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int SW = $clog2(XLEN);
  localparam int AW = $clog2(NREGS);
  localparam bit HI_REGS = (NREGS > 16);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  // Shift-immediate upper field: RV64 keeps bit 25 as shamt[5], so only bits 31:26 are checked.
  localparam logic [6:0] SRAI_FIELD = (XLEN == 64) ? 7'b0010000 : 7'b0100000;
  localparam logic [XLEN-1:0] X1_RESET = XLEN'(R1_INIT);
  localparam logic [XLEN-1:0] X2_RESET = XLEN'(R2_INIT);

  logic [XLEN-1:0] rf_r [NREGS];

  logic            idex_valid_r, idex_illegal_r, idex_alt_r;
  logic [4:0]      idex_rd_r;
  logic [2:0]      idex_f3_r;
  logic [XLEN-1:0] idex_a_r, idex_b_r;

  logic            exwb_valid_r, exwb_illegal_r;
  logic [4:0]      exwb_rd_r;
  logic [XLEN-1:0] exwb_data_r;

  logic            stall_s, accept_s, wr_en_s, ex_fwd_s, wb_fwd_s;
  logic [6:0]      opcode_s, funct7_s, shf_s;
  logic [2:0]      funct3_s;
  logic [4:0]      rd_s, rs1_s, rs2_s;
  logic            is_op_s, enc_bad_s, reg_bad_s, dec_illegal_s, dec_alt_s;
  logic [XLEN-1:0] imm_s, rf_rs1_s, rf_rs2_s, op_a_s, op_b_s, alu_s;
  logic [SW-1:0]   shamt_s;

  function automatic logic [XLEN-1:0] fwd_pick(
    input logic [4:0]      addr,
    input logic            ex_en,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_val,
    input logic            wb_en,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_val,
    input logic [XLEN-1:0] rf_val
  );
    logic [XLEN-1:0] v;
    if (ex_en && (ex_rd == addr)) begin
      v = ex_val;
    end else if (wb_en && (wb_rd == addr)) begin
      v = wb_val;
    end else begin
      v = rf_val;
    end
    return v;
  endfunction

  assign stall_s        = exwb_valid_r & ~retire_ready;
  assign instr_ready    = ~stall_s;
  assign accept_s       = instr_valid & ~stall_s;
  assign wr_en_s        = exwb_valid_r & retire_ready & ~exwb_illegal_r & (exwb_rd_r != 5'd0);
  assign retire_valid   = exwb_valid_r;
  assign retire_rd      = exwb_rd_r;
  assign retire_data    = exwb_data_r;
  assign retire_illegal = exwb_illegal_r;

  assign opcode_s = instr[6:0];
  assign rd_s     = instr[11:7];
  assign funct3_s = instr[14:12];
  assign rs1_s    = instr[19:15];
  assign rs2_s    = instr[24:20];
  assign funct7_s = instr[31:25];
  assign shf_s    = (XLEN == 64) ? {1'b0, instr[31:26]} : instr[31:25];
  assign imm_s    = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign is_op_s  = (opcode_s == OPC_OP);
  assign reg_bad_s = ~HI_REGS & (rd_s[4] | rs1_s[4] | (is_op_s & rs2_s[4]));
  assign dec_illegal_s = enc_bad_s | reg_bad_s;

  // Encoding legality and SUB/SRA selection for the instruction being offered.
  always_comb begin
    enc_bad_s = 1'b0;
    dec_alt_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        if (funct7_s == 7'b0000000) begin
          dec_alt_s = 1'b0;
        end else if ((funct7_s == 7'b0100000) && ((funct3_s == 3'b000) || (funct3_s == 3'b101))) begin
          dec_alt_s = 1'b1;
        end else begin
          enc_bad_s = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        case (funct3_s)
          3'b001: begin
            if (shf_s != 7'b0000000) begin
              enc_bad_s = 1'b1;
            end else begin
              enc_bad_s = 1'b0;
            end
          end
          3'b101: begin
            if (shf_s == 7'b0000000) begin
              dec_alt_s = 1'b0;
            end else if (shf_s == SRAI_FIELD) begin
              dec_alt_s = 1'b1;
            end else begin
              enc_bad_s = 1'b1;
            end
          end
          default: begin
            enc_bad_s = 1'b0;
          end
        endcase
      end
      default: begin
        enc_bad_s = 1'b1;
      end
    endcase
  end

  // Register file reads for the accept stage and the debug port; x0 and unimplemented registers read zero.
  always_comb begin
    rf_rs1_s = {XLEN{1'b0}};
    rf_rs2_s = {XLEN{1'b0}};
    dbg_data = {XLEN{1'b0}};
    if ((rs1_s != 5'd0) && (HI_REGS || !rs1_s[4])) begin
      rf_rs1_s = rf_r[rs1_s[AW-1:0]];
    end else begin
      rf_rs1_s = {XLEN{1'b0}};
    end
    if ((rs2_s != 5'd0) && (HI_REGS || !rs2_s[4])) begin
      rf_rs2_s = rf_r[rs2_s[AW-1:0]];
    end else begin
      rf_rs2_s = {XLEN{1'b0}};
    end
    if ((dbg_addr != 5'd0) && (HI_REGS || !dbg_addr[4])) begin
      dbg_data = rf_r[dbg_addr[AW-1:0]];
    end else begin
      dbg_data = {XLEN{1'b0}};
    end
  end

  // The retiring instruction is not yet in rf_r, so the EX/WB path also covers the write-back edge.
  assign ex_fwd_s = idex_valid_r & ~idex_illegal_r & (idex_rd_r != 5'd0);
  assign wb_fwd_s = exwb_valid_r & ~exwb_illegal_r & (exwb_rd_r != 5'd0);
  assign op_a_s = fwd_pick(rs1_s, ex_fwd_s, idex_rd_r, alu_s, wb_fwd_s, exwb_rd_r, exwb_data_r, rf_rs1_s);
  assign op_b_s = is_op_s ? fwd_pick(rs2_s, ex_fwd_s, idex_rd_r, alu_s, wb_fwd_s, exwb_rd_r, exwb_data_r, rf_rs2_s)
                          : imm_s;
  assign shamt_s = idex_b_r[SW-1:0];

  // Execute-stage ALU.
  always_comb begin
    alu_s = {XLEN{1'b0}};
    case (idex_f3_r)
      3'b000: begin
        if (idex_alt_r) begin
          alu_s = idex_a_r - idex_b_r;
        end else begin
          alu_s = idex_a_r + idex_b_r;
        end
      end
      3'b001: alu_s = idex_a_r << shamt_s;
      3'b010: alu_s = {{(XLEN-1){1'b0}}, ($signed(idex_a_r) < $signed(idex_b_r))};
      3'b011: alu_s = {{(XLEN-1){1'b0}}, (idex_a_r < idex_b_r)};
      3'b100: alu_s = idex_a_r ^ idex_b_r;
      3'b101: begin
        if (idex_alt_r) begin
          alu_s = $unsigned($signed(idex_a_r) >>> shamt_s);
        end else begin
          alu_s = idex_a_r >> shamt_s;
        end
      end
      3'b110: alu_s = idex_a_r | idex_b_r;
      3'b111: alu_s = idex_a_r & idex_b_r;
      default: alu_s = {XLEN{1'b0}};
    endcase
  end

  // ID/EX and EX/WB pipeline registers; both hold while the retire port is backpressured.
  always_ff @(posedge clock) begin
    if (reset) begin
      idex_valid_r   <= 1'b0;
      idex_illegal_r <= 1'b0;
      idex_alt_r     <= 1'b0;
      idex_rd_r      <= 5'd0;
      idex_f3_r      <= 3'd0;
      idex_a_r       <= {XLEN{1'b0}};
      idex_b_r       <= {XLEN{1'b0}};
      exwb_valid_r   <= 1'b0;
      exwb_illegal_r <= 1'b0;
      exwb_rd_r      <= 5'd0;
      exwb_data_r    <= {XLEN{1'b0}};
    end else if (!stall_s) begin
      idex_valid_r <= accept_s;
      if (accept_s) begin
        idex_illegal_r <= dec_illegal_s;
        idex_alt_r     <= dec_alt_s;
        idex_rd_r      <= rd_s;
        idex_f3_r      <= funct3_s;
        idex_a_r       <= op_a_s;
        idex_b_r       <= op_b_s;
      end
      exwb_valid_r   <= idex_valid_r;
      exwb_illegal_r <= idex_valid_r & idex_illegal_r;
      exwb_rd_r      <= (idex_valid_r & ~idex_illegal_r) ? idex_rd_r : 5'd0;
      exwb_data_r    <= (idex_valid_r & ~idex_illegal_r) ? alu_s : {XLEN{1'b0}};
    end
  end

  // Architectural register file, written on the retire handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_r[i] <= {XLEN{1'b0}};
      end
      rf_r[1] <= X1_RESET;
      rf_r[2] <= X2_RESET;
    end else if (wr_en_s) begin
      rf_r[exwb_rd_r[AW-1:0]] <= exwb_data_r;
    end
  end

endmodule

// File: doc/rv_alu_pipe.md
Name: rv_alu_pipe

Overview:
- Parametrised 3-stage integer execute pipeline: decode/operand read, execute, writeback.
- Executes RV32I/RV64I OP (0110011) and OP-IMM (0010011) instructions against an internal register file with full forwarding.
- Successor to the single-instruction mpu: adds XLEN/register-count generalisation, immediates, a valid/ready instruction input, a retire port with backpressure, and illegal-instruction flagging.
- Sits between instruction fetch and the future load/store/branch units.

Parameters:
R1_INIT, 209, reset value of x1 (sign-extended to XLEN)
R2_INIT, -208, reset value of x2 (sign-extended to XLEN)
XLEN, 32, datapath width; legal values 32 or 64
NREGS, 32, architectural registers; 32 (I) or 16 (E)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
instr_valid  in  1  instr is presented
instr_ready  out  1  pipeline can accept instr this cycle
instr  in  32  RISC-V instruction word
retire_valid  out  1  EX/WB stage holds a completed instruction
retire_ready  in  1  downstream accepts the retire beat
retire_rd  out  5  destination register; 0 if illegal
retire_data  out  XLEN  result; 0 if illegal
retire_illegal  out  1  instruction was not decodable
dbg_addr  in  5  architectural register debug read address
dbg_data  out  XLEN  regfile[dbg_addr], combinational; 0 for x0 or out-of-range

Behaviour:
- Reset (sync, active-high):
  - Both pipeline valid bits and all retire_* outputs go to 0.
  - x1 = R1_INIT, x2 = R2_INIT, all other registers 0.
  - In-flight instructions are discarded and never written.
- Stall: stall = retire_valid & !retire_ready.
  - instr_ready = !stall.
  - A handshake occurs when instr_valid & instr_ready.
  - While stalled, ID/EX and EX/WB hold their contents and retire_* outputs stay stable.
- Latency: an instruction accepted at the end of cycle c is in ID/EX during c+1 and shows retire_valid=1 in c+2 if not stalled. Throughput is 1 per cycle.
- Register file write: regfile[rd] <= retire_data on the retire handshake edge, only if !retire_illegal and rd != 0. x0 always reads 0.
- Operand forwarding, resolved combinationally in the accept cycle, in priority order:
  1. ALU output of the ID/EX instruction.
  2. EX/WB contents.
  3. Register file.
  - A forwarding source is used only if its valid bit is set, it is not illegal, and its rd is nonzero and matches.
- Opcode and funct3 decode: funct3 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
- OP encoding:
  - funct7 must be 0000000, or 0100000 for funct3 000 or 101 only.
  - bit30 selects SUB/SRA.
- OP-IMM encoding:
  - imm = sign-extended instr[31:20].
  - No SUB.
  - SLLI: instr[31:26] (XLEN=64) or instr[31:25] (XLEN=32) must be 0.
  - SRLI/SRAI: the same field must be 0, or 010000 / 0100000 respectively to select SRAI.
- Shift amount: low $clog2(XLEN) bits of rs2 or the immediate. At XLEN=32, instr[25]=1 on a shift-immediate is illegal.
- Compare results:
  - SLT compares signed; SLTU compares unsigned.
  - Result is 1 or 0, zero-extended.
- Arithmetic wraps modulo 2^XLEN. No overflow flag.
- Illegal instruction, any of:
  - Opcode other than the two above.
  - Bad funct7 or shift field.
  - NREGS=16 and any used register address has bit4=1.
  An illegal instruction still flows through the pipeline and retires with retire_illegal=1, retire_rd=0, retire_data=0. It causes no write and provides no forward.
- rd=x0: the instruction retires normally with the computed data but produces no write and no forward.
- Simultaneous retire handshake and new accept: both occur. The write of the retiring instruction is not visible through the register file until the next cycle, so the forwarding path covers it.

Test Plan:
- Reset, ADD x3,x1,x2 (0x002081B3), retire_ready=1 -> retire_valid in cycle c+2, retire_rd=3, retire_data=1; afterwards dbg_addr=3 reads 1.
- SUB x3,x1,x2 (0x402081B3) -> retire_data=417. SLTU x3,x1,x2 -> 1. SLT x3,x1,x2 -> 0. SRA x4,x2,x1 (shift 17) -> 0xFFFFFFFF.
- Back-to-back dependent: ADDI x5,x0,-1; SRLI x6,x5,28; ADD x7,x6,x5 -> retires 0xFFFFFFFF, 0x0000000F, 0x0000000E on consecutive cycles with no bubbles.
- Backpressure: hold retire_ready=0 for 3 cycles mid-stream -> instr_ready=0 and retire_* stable throughout; no instruction lost or duplicated; register writes happen exactly once per handshake.
- Illegal cases: opcode 0000011 or funct7 0100000 with funct3 100 -> retire_illegal=1, rd=0, data=0. A following ADD reading the would-be rd sees the old value.
- ADDI x0,x1,5 -> x0 still reads 0. Reset asserted while 2 instructions are in flight -> retire_valid=0 next cycle, no writes, x1=209, x2=-208. Repeat the ADD case with XLEN=64 and NREGS=16 -> retire_data=1; rs1=x17 -> illegal.
